// File: rtl/lstm_branch_cell.sv
// lstm_branch_cell: int8 LSTM cell for the branch-predictor path.
// It computes one hidden unit per MAC pass, with all four gates accumulated in parallel.
module lstm_branch_cell #(
   parameter int X_SIZE = 64,
   parameter int H_SIZE = 64,
   parameter int FRAC   = 5
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                iInit_valid,
   input  logic [7:0]          iInit_data,
   input  logic [2:0]          iInit_type,
   input  logic                iNext_valid,
   input  logic                iType,
   input  logic [X_SIZE*8-1:0] iData,
   output logic                oLstm_done,
   output logic [H_SIZE*8-1:0] oBr_Ht
);
   localparam int KN = X_SIZE + H_SIZE;
   localparam int WN = 4 * H_SIZE * KN;
   localparam int BN = 4 * H_SIZE;
   localparam int CN = 2 * H_SIZE;
   localparam int WA = $clog2(WN);
   localparam int BA = $clog2(BN);
   localparam int CW = $clog2(WN + 1);
   localparam int XA = X_SIZE > 1 ? $clog2(X_SIZE) : 1;
   localparam int HA = H_SIZE > 1 ? $clog2(H_SIZE) : 1;
   localparam int KA = $clog2(KN);
   localparam logic signed [7:0] ONE  = 8'(1 << FRAC);
   localparam logic signed [7:0] HALF = 8'(1 << (FRAC - 1));

   typedef enum logic [2:0] {S_IDLE, S_MAC, S_ACT, S_UPD, S_DONE} state_t;

   function automatic logic signed [7:0] sat8(input logic signed [23:0] v);
      return v > 24'sd127 ? 8'sh7f : v < -24'sd128 ? 8'sh80 : 8'(v);
   endfunction

   function automatic logic signed [7:0] sig8(input logic signed [7:0] x);
      logic signed [7:0] t;
      t = (x >>> 2) + HALF;
      return t < 8'sd0 ? 8'sd0 : t > ONE ? ONE : t;
   endfunction

   function automatic logic signed [7:0] tanh8(input logic signed [7:0] x);
      return x < -ONE ? -ONE : x > ONE ? ONE : x;
   endfunction

   state_t             r_state, w_nstate;
   logic signed [7:0]  r_w [WN];
   logic signed [7:0]  r_b [BN];
   logic signed [7:0]  r_c [H_SIZE];
   logic signed [7:0]  r_h [H_SIZE];
   logic signed [7:0]  r_hn [H_SIZE];
   logic signed [7:0]  r_x [X_SIZE];
   logic signed [7:0]  w_x [X_SIZE];
   logic signed [23:0] r_acc [4];
   logic signed [23:0] w_accn [4];
   logic signed [23:0] w_binit [4];
   logic signed [15:0] w_prod [4];
   logic signed [7:0]  w_pre [4];
   logic signed [7:0]  w_act [4];
   logic signed [7:0]  r_g [4];
   logic [WA-1:0]      w_widx [4];
   logic [BA-1:0]      w_bidx [4];
   logic signed [7:0]  w_op;
   logic signed [15:0] w_fc, w_ig, w_oc;
   logic signed [7:0]  w_cn, w_hn;
   logic [HA-1:0]      r_j, w_jn;
   logic [KA-1:0]      r_k;
   logic [CW-1:0]      r_cnt, w_addr;
   logic [2:0]         r_ltype;
   logic               r_lvalid;
   logic               w_start, w_last_k, w_last_j, w_ld, w_ctx;

   assign w_start  = r_state == S_IDLE && iNext_valid && !iType;
   assign w_last_k = r_k == KA'(KN - 1);
   assign w_last_j = r_j == HA'(H_SIZE - 1);
   assign w_jn     = (r_state == S_UPD) ? r_j + 1'b1 : '0;
   assign w_op     = (r_k < KA'(X_SIZE)) ? r_x[XA'(r_k)] : r_h[HA'(r_k - KA'(X_SIZE))];
   assign oLstm_done = r_state == S_IDLE;

   // The stream counter restarts on a valid gap or a type switch, and it saturates so that overlong streams cannot wrap.
   assign w_addr = (r_lvalid && iInit_type == r_ltype) ? r_cnt : '0;
   assign w_ld   = iInit_valid && r_state == S_IDLE;
   assign w_ctx  = w_ld && iInit_type == 3'd5 && w_addr < CW'(CN);

   for (genvar g = 0; g < 4; g++) begin : g_gate
      assign w_widx[g]  = WA'(g * H_SIZE * KN) + WA'(r_j) * WA'(KN) + WA'(r_k);
      assign w_prod[g]  = r_w[w_widx[g]] * w_op;
      assign w_accn[g]  = r_acc[g] + 24'(w_prod[g]);
      assign w_bidx[g]  = BA'(g * H_SIZE) + BA'(w_jn);
      assign w_binit[g] = 24'(r_b[w_bidx[g]]) <<< FRAC;
      assign w_pre[g]   = sat8(r_acc[g] >>> FRAC);
      assign w_act[g]   = (g == 2) ? tanh8(w_pre[g]) : sig8(w_pre[g]);
   end

   assign w_fc = r_g[1] * r_c[r_j];
   assign w_ig = r_g[0] * r_g[2];
   assign w_cn = sat8((24'(w_fc) + 24'(w_ig)) >>> FRAC);
   assign w_oc = r_g[3] * tanh8(w_cn);
   assign w_hn = sat8(24'(w_oc) >>> FRAC);

   for (genvar n = 0; n < X_SIZE; n++) begin : g_in
      assign w_x[n] = iData[(X_SIZE-1-n)*8 +: 8];
   end
   for (genvar n = 0; n < H_SIZE; n++) begin : g_out
      assign oBr_Ht[(H_SIZE-1-n)*8 +: 8] = r_h[n];
   end

   always_comb begin
      w_nstate = r_state;
      case (r_state)
         S_IDLE:  w_nstate = w_start ? S_MAC : S_IDLE;
         S_MAC:   w_nstate = w_last_k ? S_ACT : S_MAC;
         S_ACT:   w_nstate = S_UPD;
         S_UPD:   w_nstate = w_last_j ? S_DONE : S_MAC;
         default: w_nstate = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_ld && iInit_type == 3'd2 && w_addr < CW'(WN)) r_w[WA'(w_addr)] <= iInit_data;
      if (w_ld && iInit_type == 3'd3 && w_addr < CW'(BN)) r_b[BA'(w_addr)] <= iInit_data;
   end

   // h_prev is read from r_h throughout a step while the new values collect in r_hn.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state  <= S_IDLE;
         r_j      <= '0;
         r_k      <= '0;
         r_cnt    <= '0;
         r_ltype  <= '0;
         r_lvalid <= 1'b0;
         r_acc    <= '{default: '0};
         r_g      <= '{default: '0};
         r_c      <= '{default: '0};
         r_h      <= '{default: '0};
         r_hn     <= '{default: '0};
         r_x      <= '{default: '0};
      end else begin
         r_state  <= w_nstate;
         r_lvalid <= iInit_valid;
         r_ltype  <= iInit_type;
         r_cnt    <= !iInit_valid ? '0 : w_addr == CW'(WN) ? w_addr : w_addr + 1'b1;
         if (w_ctx && w_addr < CW'(H_SIZE)) r_c[HA'(w_addr)] <= iInit_data;
         if (w_ctx && w_addr >= CW'(H_SIZE)) r_h[HA'(w_addr - CW'(H_SIZE))] <= iInit_data;
         if (w_start) r_x <= w_x;
         if (w_start || (r_state == S_UPD && !w_last_j)) r_acc <= w_binit;
         if (r_state == S_MAC) r_acc <= w_accn;
         r_k <= (r_state == S_MAC && !w_last_k) ? r_k + 1'b1 : '0;
         if (r_state == S_ACT) r_g <= w_act;
         if (r_state == S_UPD) begin
            r_c[r_j]  <= w_cn;
            r_hn[r_j] <= w_hn;
            r_j       <= w_last_j ? '0 : r_j + 1'b1;
         end
         if (r_state == S_DONE) r_h <= r_hn;
      end
   end
endmodule

// File: tb/tb_lstm_branch_cell.sv
// tb_lstm_branch_cell: directed and randomized steps on a reduced-size cell.
// The steps are checked against an integer reference model.
module tb_lstm_branch_cell;
   localparam int X = 6, H = 4, F = 5, KN = X + H, LAT = H * (KN + 2) + 1;

   logic           clk = 0, resetn = 1, iInit_valid = 0, iNext_valid = 0, iType = 0;
   logic [7:0]     iInit_data = 0;
   logic [2:0]     iInit_type = 0;
   logic [X*8-1:0] iData = 0;
   logic           oLstm_done;
   logic [H*8-1:0] oBr_Ht;
   int n_tests = 0, n_fail = 0, cyc = 0;
   int mw[4][H][KN], mb[4][H], mc[H], mh[H], mx[X];

   lstm_branch_cell #(.X_SIZE(X), .H_SIZE(H), .FRAC(F)) dut (
      .clk(clk), .resetn(resetn), .iInit_valid(iInit_valid), .iInit_data(iInit_data),
      .iInit_type(iInit_type), .iNext_valid(iNext_valid), .iType(iType), .iData(iData),
      .oLstm_done(oLstm_done), .oBr_Ht(oBr_Ht)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic int sat(input int v);
      return v > 127 ? 127 : v < -128 ? -128 : v;
   endfunction

   function automatic int clampi(input int v, input int lo, input int hi);
      return v < lo ? lo : v > hi ? hi : v;
   endfunction

   function automatic int rnd(input int lo, input int hi);
      return lo + int'($urandom_range(hi - lo));
   endfunction

   function automatic void model_step();
      int hn[H];
      int a, p;
      int act[4];
      for (int j = 0; j < H; j++) begin
         for (int g = 0; g < 4; g++) begin
            a = mb[g][j] * (1 << F);
            for (int k = 0; k < KN; k++) a += mw[g][j][k] * (k < X ? mx[k] : mh[k-X]);
            p = sat(a >>> F);
            act[g] = (g == 2) ? clampi(p, -32, 32) : clampi((p >>> 2) + 16, 0, 32);
         end
         mc[j] = sat((act[1] * mc[j] + act[0] * act[2]) >>> F);
         hn[j] = sat((act[3] * clampi(mc[j], -32, 32)) >>> F);
      end
      mh = hn;
   endfunction

   function automatic logic [H*8-1:0] model_ht();
      logic [H*8-1:0] r;
      for (int j = 0; j < H; j++) r[(H-1-j)*8 +: 8] = 8'(mh[j]);
      return r;
   endfunction

   function automatic void model_clear();
      for (int g = 0; g < 4; g++)
         for (int j = 0; j < H; j++) begin
            mb[g][j] = 0;
            for (int k = 0; k < KN; k++) mw[g][j][k] = 0;
         end
      for (int j = 0; j < H; j++) begin mc[j] = 0; mh[j] = 0; end
      for (int k = 0; k < X; k++) mx[k] = rnd(-128, 127);
   endfunction

   task automatic send(input logic [2:0] t, input int d);
      @(negedge clk);
      iInit_valid = 1; iInit_type = t; iInit_data = 8'(d);
   endtask

   task automatic idle();
      @(negedge clk);
      iInit_valid = 0;
   endtask

   task automatic send_w();
      for (int g = 0; g < 4; g++)
         for (int j = 0; j < H; j++)
            for (int k = 0; k < KN; k++) send(3'd2, mw[g][j][k]);
   endtask

   task automatic send_b();
      for (int g = 0; g < 4; g++)
         for (int j = 0; j < H; j++) send(3'd3, mb[g][j]);
   endtask

   task automatic send_ctx();
      for (int j = 0; j < H; j++) send(3'd5, mc[j]);
      for (int j = 0; j < H; j++) send(3'd5, mh[j]);
   endtask

   task automatic start();
      logic [X*8-1:0] xv;
      for (int k = 0; k < X; k++) xv[(X-1-k)*8 +: 8] = 8'(mx[k]);
      @(negedge clk);
      iData = xv; iNext_valid = 1; iType = 0;
      @(negedge clk);
      iNext_valid = 0; iData = X*8'({$urandom(), $urandom()});
   endtask

   task automatic step(input string tag, input bit busy_load);
      int t0;
      start();
      t0 = cyc;
      check({tag, "_busy"}, oLstm_done, 0);
      if (busy_load) begin
         for (int n = 0; n < 3; n++) send(3'd5, 8'h55);
         idle();
      end
      while (!oLstm_done && cyc - t0 < 4 * LAT) @(negedge clk);
      check({tag, "_latency"}, cyc - t0, LAT);
      model_step();
      check({tag, "_ht"}, oBr_Ht, model_ht());
   endtask

   initial begin
      #2 resetn = 0;
      #10;
      check("rst_done", oLstm_done, 1);
      check("rst_ht", oBr_Ht, 0);
      @(negedge clk) resetn = 1;

      model_clear();
      send_w(); send_b(); idle();
      step("zero", 0);
      check("zero_const", oBr_Ht, 0);

      for (int j = 0; j < H; j++) mb[2][j] = 32;
      send_b(); idle();
      step("bg1", 0);
      check("bg1_const", oBr_Ht, {H{8'h08}});
      step("bg2", 0);
      check("bg2_const", oBr_Ht, {H{8'h0C}});

      @(negedge clk) begin iNext_valid = 1; iType = 1; end
      @(negedge clk) iNext_valid = 0;
      check("itype1_ignored", oLstm_done, 1);
      iType = 0;

      for (int g = 0; g < 4; g++) for (int j = 0; j < H; j++) mb[g][j] = 127;
      for (int j = 0; j < H; j++) begin mc[j] = 0; mh[j] = 0; end
      send_b(); send_ctx(); idle();
      step("sat", 0);
      check("sat_const", oBr_Ht, {H{8'h20}});

      for (int g = 0; g < 4; g++) for (int j = 0; j < H; j++) mb[g][j] = (g == 1) ? 127 : 0;
      for (int j = 0; j < H; j++) begin mc[j] = 32; mh[j] = 5; end
      send_b(); send_ctx(); idle();
      check("ctx_load_ht", oBr_Ht, {H{8'h05}});
      step("ctx", 0);
      check("ctx_const", oBr_Ht, {H{8'h10}});

      model_clear();
      for (int g = 0; g < 4; g++) mw[g][2][0] = 32;
      mx[0] = 32;
      send_w(); send_b();
      idle();
      send_ctx();
      for (int n = 0; n < 4; n++) send(3'd5, 8'h7f);
      idle();
      check("ctx_overflow_ht", oBr_Ht, 0);
      step("wcol", 0);
      check("wcol_const", oBr_Ht, 32'h0000_1200);

      for (int r = 0; r < 3; r++) begin
         for (int g = 0; g < 4; g++)
            for (int j = 0; j < H; j++) begin
               mb[g][j] = rnd(-40, 40);
               for (int k = 0; k < KN; k++) mw[g][j][k] = rnd(-8, 7);
            end
         for (int j = 0; j < H; j++) begin mc[j] = rnd(-40, 40); mh[j] = rnd(-40, 40); end
         for (int k = 0; k < X; k++) mx[k] = rnd(-128, 127);
         send_w(); idle(); send_b(); idle(); send_ctx(); idle();
         check("rnd_ctx_ht", oBr_Ht, model_ht());
         step("rnd_a", r == 1);
         for (int k = 0; k < X; k++) mx[k] = rnd(-128, 127);
         step("rnd_b", 0);
      end

      model_clear();
      for (int j = 0; j < H; j++) mb[2][j] = 32;
      send_w(); idle(); send_b(); idle();
      start();
      repeat (20) @(negedge clk);
      check("mid_busy", oLstm_done, 0);
      #2 resetn = 0;
      #1;
      check("mid_rst_done", oLstm_done, 1);
      check("mid_rst_ht", oBr_Ht, 0);
      @(negedge clk) resetn = 1;
      for (int j = 0; j < H; j++) begin mc[j] = 0; mh[j] = 0; end
      step("after_rst", 0);
      check("after_rst_const", oBr_Ht, {H{8'h08}});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
